kara32_seq_ctrl: RTL and testbench

- Sequencer that computes a 32x32 unsigned product with a single shared 18x18 multiplier (exact or radix-4 approximate), using three-pass Karatsuba.
- The multiplier instance sits outside the block. The block drives its operands, captures its 36-bit result per phase, and combines the partial products into a 64-bit result.
- It is the top-level control for the 32-bit double-approximate Karatsuba datapath.

---
 rtl/kara32_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_kara32_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kara32_seq_ctrl.sv
// Three-pass Karatsuba sequencer for a shared 18x18 multiplier.
// Optional sticky middle-term clamp enabled by KARA_MID_CLAMP_EN.
module kara32_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [17:0] mul_x,
  output logic [17:0] mul_y,
  input  logic [35:0] mul_p,
  output logic        mid_clamp
);

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    MID,
    COMB
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [35:0]     z0;
  logic [35:0]     z1;
  logic [35:0]     z2;
  logic [16:0]     sum_a;
  logic [16:0]     sum_b;
  logic [63:0]     zs;
  logic [63:0]     mid_raw;
  logic [63:0]     mid;
  logic [63:0]     comb_res;

  assign last  = (cnt == CW'(MUL_LAT));
  assign sum_a = {1'b0, a_q[15:0]} + {1'b0, a_q[31:16]};
  assign sum_b = {1'b0, b_q[15:0]} + {1'b0, b_q[31:16]};

  always_comb begin
    state_n = state;
    mul_x   = '0;
    mul_y   = '0;
    unique case (state)
      IDLE: if (start) state_n = LO;
      LO: begin
        mul_x = {2'b0, a_q[15:0]};
        mul_y = {2'b0, b_q[15:0]};
        if (last) state_n = HI;
      end
      HI: begin
        mul_x = {2'b0, a_q[31:16]};
        mul_y = {2'b0, b_q[31:16]};
        if (last) state_n = MID;
      end
      MID: begin
        mul_x = {1'b0, sum_a};
        mul_y = {1'b0, sum_b};
        if (last) state_n = COMB;
      end
      COMB:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Middle term may go negative with an approximate multiplier
  assign zs      = {28'b0, z2} + {28'b0, z0};
  assign mid_raw = {28'b0, z1} - zs;

`ifdef KARA_MID_CLAMP_EN
  logic clamp_hit;
  assign clamp_hit = ({28'b0, z1} < zs);
  assign mid       = clamp_hit ? 64'd0 : mid_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_clamp <= 1'b0;
    end else if (state == IDLE && start) begin
      mid_clamp <= 1'b0;
    end else if (state == COMB && clamp_hit) begin
      mid_clamp <= 1'b1;
    end
  end
`else
  assign mid       = mid_raw;
  assign mid_clamp = 1'b0;
`endif

  assign comb_res = ({28'b0, z2} << 32) + (mid << 16) + {28'b0, z0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z0      <= '0;
      z1      <= '0;
      z2      <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (state inside {LO, HI, MID} && !last)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
          end
        end
        LO:  if (last) z0 <= mul_p;
        HI:  if (last) z2 <= mul_p;
        MID: if (last) z1 <= mul_p;
        COMB: begin
          product <= comb_res;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kara32_seq_ctrl.sv
// Scoreboard bench for kara32_seq_ctrl at MUL_LAT=0 and MUL_LAT=2.
// Clamp expectations follow KARA_MID_CLAMP_EN.
module tb_kara32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic        busy0;
  logic        done0;
  logic [63:0] prod0;
  logic [17:0] x0;
  logic [17:0] y0;
  logic [35:0] p0;
  logic        clamp0;
  logic        stub0 = 1'b0;

  logic        start2 = 1'b0;
  logic [31:0] a2 = '0;
  logic [31:0] b2 = '0;
  logic        busy2;
  logic        done2;
  logic [63:0] prod2;
  logic [17:0] x2;
  logic [17:0] y2;
  logic [35:0] p2;
  logic        clamp2;
  logic [35:0] pa = '0;
  logic [35:0] pb = '0;

  int passed = 0;
  int total  = 0;
  logic [63:0] q0[$];
  logic [63:0] q2[$];

  always #5 clk = ~clk;

  // Exact model; stub forces zero for the MID operand of 0x00010001
  assign p0 = (stub0 && x0 == 18'd2) ? 36'd0 :
              {18'b0, x0} * {18'b0, y0};

  always @(posedge clk) begin
    pa <= {18'b0, x2} * {18'b0, y2};
    pb <= pa;
  end
  assign p2 = pb;

  kara32_seq_ctrl #(.MUL_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .product(prod0),
    .mul_x(x0), .mul_y(y0), .mul_p(p0), .mid_clamp(clamp0)
  );

  kara32_seq_ctrl #(.MUL_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(prod2),
    .mul_x(x2), .mul_y(y2), .mul_p(p2), .mid_clamp(clamp2)
  );

  task automatic drive0(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] expv, input bit now);
    if (!now) @(negedge clk);
    start0 = 1'b1;
    a0 = av;
    b0 = bv;
    q0.push_back(expv);
    @(posedge clk);
    #1;
    start0 = 1'b0;
  endtask

  task automatic wait0(output int lat, output int bcnt, output bit ok);
    lat  = 0;
    ok   = 1'b0;
    bcnt = busy0 ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
      if (busy0) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy0 !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy0);
    else passed++;
    total++;
    if (done0 !== 1'b0) $display("FAIL reset_done got %0b want 0", done0);
    else passed++;
    total++;
    if (prod0 !== 64'd0) $display("FAIL reset_product got %h want 0", prod0);
    else passed++;
    total++;
    if ({x0, y0} !== 36'd0) $display("FAIL reset_mul_xy got %h want 0", {x0, y0});
    else passed++;
    total++;
    if (clamp0 !== 1'b0) $display("FAIL reset_clamp got %0b want 0", clamp0);
    else passed++;
    total++;
    if ({busy2, done2, prod2} !== 66'd0)
      $display("FAIL reset_lat2 got %h want 0", {busy2, done2, prod2});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    bit ok;
    logic [63:0] e;
    drive0(32'd2, 32'd2881, 64'd2 * 64'd2881, 1'b0);
    wait0(lat, bc, ok);
    e = q0.pop_front();
    total++;
    if (!ok || prod0 !== e) $display("FAIL basic_product got %0d want %0d ok=%0b", prod0, e, ok);
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat);
    else passed++;
    total++;
    if (bc !== 4) $display("FAIL basic_busy_cycles got %0d want 4", bc);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (done0 !== 1'b0) $display("FAIL basic_done_pulse got %0b want 0", done0);
    else passed++;
  endtask

  task automatic test_corners;
    int lat, bc;
    bit ok;
    logic [63:0] e;
    logic [31:0] av [2];
    logic [31:0] bv [2];
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF;
    av[1] = 32'h0;         bv[1] = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      drive0(av[k], bv[k], {32'b0, av[k]} * {32'b0, bv[k]}, 1'b0);
      wait0(lat, bc, ok);
      e = q0.pop_front();
      total++;
      if (!ok || prod0 !== e) $display("FAIL corner%0d_product got %h want %h", k, prod0, e);
      else passed++;
      total++;
      if (lat !== 4) $display("FAIL corner%0d_latency got %0d want 4", k, lat);
      else passed++;
    end
    total++;
    if (e !== 64'd0 || {32'b0, av[0]} * {32'b0, bv[0]} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL corner_model got %h want 0", e);
    else passed++;
  endtask

  task automatic test_latency;
    logic [31:0] av, bv;
    logic [17:0] xs [10];
    logic [17:0] xe;
    logic [63:0] e;
    int lat, bad;
    av = 32'h0001_0003;
    bv = 32'h0002_0005;
    lat = 0;
    @(negedge clk);
    start2 = 1'b1; a2 = av; b2 = bv;
    q2.push_back({32'b0, av} * {32'b0, bv});
    @(posedge clk);
    #1;
    start2 = 1'b0;
    xs[0] = x2;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = i;
        break;
      end
      if (i < 10) xs[i] = x2;
    end
    e = q2.pop_front();
    total++;
    if (prod2 !== e || e !== 64'h0000_0002_000B_000F)
      $display("FAIL lat2_product got %h want %h", prod2, e);
    else passed++;
    total++;
    if (lat !== 10) $display("FAIL lat2_latency got %0d want 10", lat);
    else passed++;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      case (k / 3)
        0:       xe = {2'b0, av[15:0]};
        1:       xe = {2'b0, av[31:16]};
        2:       xe = {1'b0, {1'b0, av[15:0]} + {1'b0, av[31:16]}};
        default: xe = 18'd0;
      endcase
      if (xs[k] !== xe) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL lat2_mul_x_hold got %0d bad samples want 0", bad);
    else passed++;
  endtask

  task automatic test_ignore;
    int lat, bc, extra;
    bit ok;
    logic [63:0] e;
    drive0(32'd5, 32'd6, 64'd30, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start0 = 1'b1; a0 = 32'd100; b0 = 32'd100;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait0(lat, bc, ok);
    e = q0.pop_front();
    total++;
    if (!ok || prod0 !== e) $display("FAIL ignore_product got %0d want %0d", prod0, e);
    else passed++;
    total++;
    if (lat + 2 !== 4) $display("FAIL ignore_latency got %0d want 4", lat + 2);
    else passed++;
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL ignore_no_queue got %0d activity want 0", extra);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    bit ok;
    logic [63:0] e;
    drive0(32'd3, 32'd4, 64'd12, 1'b0);
    wait0(lat, bc, ok);
    e = q0.pop_front();
    total++;
    if (!ok || prod0 !== e) $display("FAIL b2b_first got %0d want %0d", prod0, e);
    else passed++;
    drive0(32'd11, 32'd13, 64'd143, 1'b1);
    wait0(lat, bc, ok);
    e = q0.pop_front();
    total++;
    if (!ok || prod0 !== e) $display("FAIL b2b_second got %0d want %0d", prod0, e);
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL b2b_latency got %0d want 4", lat);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    bit ok;
    logic [63:0] e;
    drive0(32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy0 !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy0);
    else passed++;
    total++;
    if (prod0 !== 64'd0) $display("FAIL rstmid_product got %h want 0", prod0);
    else passed++;
    rst = 1'b0;
    void'(q0.pop_front());
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done0) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL rstmid_no_done got %0d want 0", seen);
    else passed++;
    drive0(32'd7, 32'd9, 64'd63, 1'b0);
    wait0(lat, bc, ok);
    e = q0.pop_front();
    total++;
    if (!ok || prod0 !== e) $display("FAIL rstmid_after got %0d want %0d", prod0, e);
    else passed++;
  endtask

  task automatic test_clamp;
    int lat, bc;
    bit ok;
    logic [63:0] e;
    logic ce;
`ifdef KARA_MID_CLAMP_EN
    ce = 1'b1;
    e  = 64'h0000_0001_0000_0001;
`else
    ce = 1'b0;
    e  = 64'h0000_0000_FFFE_0001;
`endif
    stub0 = 1'b1;
    drive0(32'h0001_0001, 32'h0001_0001, e, 1'b0);
    wait0(lat, bc, ok);
    e = q0.pop_front();
    stub0 = 1'b0;
    total++;
    if (!ok || prod0 !== e) $display("FAIL clamp_product got %h want %h", prod0, e);
    else passed++;
    total++;
    if (clamp0 !== ce) $display("FAIL clamp_flag got %0b want %0b", clamp0, ce);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_latency();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
